// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the two handshakes owned by the fetch stage:
//   - instruction memory read port : mem_req, mem_addr, mem_ack, mem_rdata
//   - decoder instruction port     : instr, instr_pc, instr_valid, instr_ready
// Modports:
//   master : the fetch unit (drives requests and the instruction register)
//   slave  : the memory/decoder side (drives ack, read data and ready)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage downstream of the PC. Samples pc_val, issues one
// outstanding read to instruction memory, latches the returned word and offers
// it to the decoder with valid/ready. Pulses pc_inc once per captured word and
// holds the PC (pc_disable) while a fetch is outstanding or a word is held.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   clr        in   synchronous active-high reset
//   fetch_en   in   permits launching a new fetch
//   flush      in   discard in-flight fetch and held instruction
//   pc_val     in   current PC
//   pc_inc     out  one-cycle pulse: instruction captured
//   pc_disable out  high whenever the unit is not IDLE
//   fetch_err  out  sticky memory-timeout flag
//   misalign   out  sticky misaligned-PC flag
//   bus        master modport of fetch_unit_if (memory + decoder handshakes)
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN  defined   -> misaligned PC raises misalign, no fetch
//                           undefined -> low PC bits dropped, misalign stays 0
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned TMR_W        = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        fetch_en,
    input  logic        flush,
    input  logic [31:0] pc_val,
    output logic        pc_inc,
    output logic        pc_disable,
    output logic        fetch_err,
    output logic        misalign,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WAIT_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              pc_inc_q, pc_inc_d;
    logic              pc_disable_q, pc_disable_d;
    logic              fetch_err_q, fetch_err_d;
    logic              misalign_q, misalign_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic              launch_ok;
    logic              pc_misaligned;

    // A sticky error (timeout or misalign trap) freezes launching until flush/clr.
    assign launch_ok     = fetch_en && !fetch_err_q && !misalign_q;
    assign pc_misaligned = TRAP_EN && (pc_val[1:0] != 2'b00);

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path through
        // the case statement can leave a signal unassigned and infer a latch.
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pc_inc_d      = 1'b0;
        fetch_err_d   = fetch_err_q;
        misalign_d    = misalign_q;
        timer_d       = timer_q;

        if (flush) begin
            // Flush wins over any same-cycle ack: the returned word is dropped.
            state_d       = S_IDLE;
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            fetch_err_d   = 1'b0;
            misalign_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (launch_ok && pc_misaligned) begin
                        misalign_d = 1'b1;
                    end else if (launch_ok) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {pc_val[31:2], 2'b00};
                        timer_d    = '0;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An ack on the final wait cycle still counts as success.
                    if (mem_req_q && bus.mem_ack) begin
                        mem_req_d     = 1'b0;
                        instr_d       = bus.mem_rdata;
                        instr_pc_d    = mem_addr_q;
                        instr_valid_d = 1'b1;
                        pc_inc_d      = 1'b1;
                        state_d       = S_HOLD;
                    end else if (timer_q == TMR_LAST) begin
                        mem_req_d   = 1'b0;
                        fetch_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_IDLE;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end

        // Registered from the next state so pc_disable lines up with the state.
        pc_disable_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: the instruction register is reset (to the NOP) like every other
        // flop here, so the decoder never sees an undefined word after clr.
        if (clr) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            pc_inc_q      <= 1'b0;
            pc_disable_q  <= 1'b0;
            fetch_err_q   <= 1'b0;
            misalign_q    <= 1'b0;
            timer_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all flops sampling the same
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            pc_inc_q      <= pc_inc_d;
            pc_disable_q  <= pc_disable_d;
            fetch_err_q   <= fetch_err_d;
            misalign_q    <= misalign_d;
            timer_q       <= timer_d;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign pc_inc          = pc_inc_q;
    assign pc_disable      = pc_disable_q;
    assign fetch_err       = fetch_err_q;
    assign misalign        = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (WAIT_TIMEOUT overridden to 4). A table of
// per-cycle vectors covers reset and two back-to-back fetches; hand-written
// sequences cover decoder back-pressure, flush vs. ack, timeout, clr mid-fetch
// and the misaligned-PC behaviour of whichever build is compiled.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        clr;
    logic        fetch_en;
    logic        flush;
    logic [31:0] pc_val;
    logic        pc_inc;
    logic        pc_disable;
    logic        fetch_err;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    fetch_unit_if bus ();

    fetch_unit #(
        .NOP_INSTR    (NOP),
        .WAIT_TIMEOUT (4),
        .TMR_W        (16)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .fetch_en   (fetch_en),
        .flush      (flush),
        .pc_val     (pc_val),
        .pc_inc     (pc_inc),
        .pc_disable (pc_disable),
        .fetch_err  (fetch_err),
        .misalign   (misalign),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        clr;
        logic        en;
        logic        fl;
        logic        ack;
        logic        rdy;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_valid;
        logic        e_inc;
        logic        e_dis;
        logic        e_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic en, input logic fl, input logic [31:0] pc,
                         input logic ack, input logic [31:0] rdata, input logic rdy);
        clr           = c;
        fetch_en      = en;
        flush         = fl;
        pc_val        = pc;
        bus.mem_ack   = ack;
        bus.mem_rdata = rdata;
        bus.instr_ready = rdy;
    endtask

    // Advance one edge and sample 1 time unit later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        //            name        clr   en    fl    ack   rdy   pc     rdata          req   addr   instr          ipc    valid inc   dis   err
        vecs[0] = '{"reset",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b0, 32'd0, NOP,           32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"launch0",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0,         1'b1, 32'd0, NOP,           32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"wait0",     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0,         1'b1, 32'd0, NOP,           32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"ack0",      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'h00500093,  1'b0, 32'd0, 32'h00500093,  32'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{"hs0",       1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0,         1'b0, 32'd0, 32'h00500093,  32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"launch4",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd4, 32'h0,         1'b1, 32'd4, 32'h00500093,  32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{"ack4",      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd4, 32'h00a00113,  1'b0, 32'd4, 32'h00a00113,  32'd4, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{"hs4",       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4, 32'h0,         1'b0, 32'd4, 32'h00a00113,  32'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{"stray_ack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd8, 32'hdeadbeef,  1'b0, 32'd4, 32'h00a00113,  32'd4, 1'b0, 1'b0, 1'b0, 1'b0};

        tick();

        // Table: reset, two back-to-back fetches, ack ignored while idle.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].clr, vecs[i].en, vecs[i].fl, vecs[i].pc,
                  vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
            tick();
            check1 ({vecs[i].name, ".mem_req"},     bus.mem_req,     vecs[i].e_req);
            check32({vecs[i].name, ".mem_addr"},    bus.mem_addr,    vecs[i].e_addr);
            check32({vecs[i].name, ".instr"},       bus.instr,       vecs[i].e_instr);
            check32({vecs[i].name, ".instr_pc"},    bus.instr_pc,    vecs[i].e_ipc);
            check1 ({vecs[i].name, ".instr_valid"}, bus.instr_valid, vecs[i].e_valid);
            check1 ({vecs[i].name, ".pc_inc"},      pc_inc,          vecs[i].e_inc);
            check1 ({vecs[i].name, ".pc_disable"},  pc_disable,      vecs[i].e_dis);
            check1 ({vecs[i].name, ".fetch_err"},   fetch_err,       vecs[i].e_err);
        end
        check1("reset.misalign", misalign, 1'b0);

        // Decoder back-pressure; fetch_en dropped mid-wait does not cancel.
        drive(1'b0, 1'b1, 1'b0, 32'd8, 1'b0, 32'h0, 1'b0);
        tick();
        check1 ("bp.launch_req", bus.mem_req, 1'b1);
        check32("bp.launch_addr", bus.mem_addr, 32'd8);
        drive(1'b0, 1'b0, 1'b0, 32'd8, 1'b0, 32'h0, 1'b0);
        tick();
        check1 ("bp.en_low_keeps_req", bus.mem_req, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'd8, 1'b1, 32'h00c00193, 1'b0);
        tick();
        check1 ("bp.capture_inc", pc_inc, 1'b1);
        check32("bp.capture_instr", bus.instr, 32'h00c00193);
        drive(1'b0, 1'b1, 1'b0, 32'd12, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check1 ("bp.hold_valid", bus.instr_valid, 1'b1);
            check32("bp.hold_instr", bus.instr, 32'h00c00193);
            check1 ("bp.hold_req", bus.mem_req, 1'b0);
            check1 ("bp.hold_dis", pc_disable, 1'b1);
            check1 ("bp.hold_inc", pc_inc, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd12, 1'b0, 32'h0, 1'b1);
        tick();
        check1("bp.release_valid", bus.instr_valid, 1'b0);
        check1("bp.release_dis", pc_disable, 1'b0);

        // Flush in the same cycle as mem_ack.
        drive(1'b0, 1'b1, 1'b0, 32'd8, 1'b0, 32'h0, 1'b1);
        tick();
        check1("fl.launch_req", bus.mem_req, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'd8, 1'b1, 32'h11111111, 1'b1);
        tick();
        check1 ("fl.inc", pc_inc, 1'b0);
        check32("fl.instr", bus.instr, NOP);
        check1 ("fl.valid", bus.instr_valid, 1'b0);
        check1 ("fl.req", bus.mem_req, 1'b0);
        check1 ("fl.dis", pc_disable, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'd32, 1'b0, 32'h0, 1'b1);
        tick();
        check1 ("fl.next_req", bus.mem_req, 1'b1);
        check32("fl.next_addr", bus.mem_addr, 32'd32);
        drive(1'b0, 1'b0, 1'b0, 32'd32, 1'b1, 32'h22222222, 1'b1);
        tick();
        check1 ("fl.next_inc", pc_inc, 1'b1);
        check32("fl.next_ipc", bus.instr_pc, 32'd32);
        drive(1'b0, 1'b0, 1'b0, 32'd36, 1'b0, 32'h0, 1'b1);
        tick();
        check1("fl.next_hs", bus.instr_valid, 1'b0);

        // Timeout after 4 request cycles; launches blocked until flush.
        drive(1'b0, 1'b1, 1'b0, 32'd12, 1'b0, 32'h0, 1'b1);
        tick();
        check1("to.req_0", bus.mem_req, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check1("to.req_held", bus.mem_req, 1'b1);
            check1("to.err_low", fetch_err, 1'b0);
        end
        tick();
        check1("to.req_drop", bus.mem_req, 1'b0);
        check1("to.err_set", fetch_err, 1'b1);
        check1("to.dis", pc_disable, 1'b0);
        check1("to.no_inc", pc_inc, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'd12, 1'b1, 32'h33333333, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("to.blocked_req", bus.mem_req, 1'b0);
            check1("to.blocked_err", fetch_err, 1'b1);
            check1("to.blocked_inc", pc_inc, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1, 32'd12, 1'b0, 32'h0, 1'b1);
        tick();
        check1("to.flush_err", fetch_err, 1'b0);
        check1("to.flush_req", bus.mem_req, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'd16, 1'b0, 32'h0, 1'b1);
        tick();
        check1 ("to.relaunch_req", bus.mem_req, 1'b1);
        check32("to.relaunch_addr", bus.mem_addr, 32'd16);

        // Ack on the last permitted wait cycle is a success, not a timeout.
        drive(1'b0, 1'b0, 1'b0, 32'd16, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check1("late.req_still", bus.mem_req, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 32'h44444444, 1'b1);
        tick();
        check1 ("late.inc", pc_inc, 1'b1);
        check1 ("late.err", fetch_err, 1'b0);
        check32("late.instr", bus.instr, 32'h44444444);
        drive(1'b0, 1'b0, 1'b0, 32'd20, 1'b0, 32'h0, 1'b1);
        tick();
        check1("late.hs", bus.instr_valid, 1'b0);

        // clr in the middle of a fetch.
        drive(1'b0, 1'b1, 1'b0, 32'd20, 1'b0, 32'h0, 1'b1);
        tick();
        check1("clr.launch_req", bus.mem_req, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'd20, 1'b0, 32'h0, 1'b1);
        tick();
        check1 ("clr.req", bus.mem_req, 1'b0);
        check32("clr.addr", bus.mem_addr, 32'd0);
        check32("clr.instr", bus.instr, NOP);
        check32("clr.ipc", bus.instr_pc, 32'd0);
        check1 ("clr.dis", pc_disable, 1'b0);

        // Misaligned PC.
        drive(1'b0, 1'b1, 1'b0, 32'd6, 1'b0, 32'h0, 1'b1);
        tick();
`ifdef FETCH_MISALIGN_TRAP_EN
        check1("mis.flag", misalign, 1'b1);
        check1("mis.req", bus.mem_req, 1'b0);
        check1("mis.dis", pc_disable, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'd8, 1'b0, 32'h0, 1'b1);
        tick();
        check1("mis.blocked_req", bus.mem_req, 1'b0);
        check1("mis.sticky", misalign, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'd8, 1'b0, 32'h0, 1'b1);
        tick();
        check1("mis.flush_clears", misalign, 1'b0);
`else
        check1 ("mis.req", bus.mem_req, 1'b1);
        check32("mis.addr", bus.mem_addr, 32'd4);
        check1 ("mis.flag", misalign, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd6, 1'b1, 32'h55555555, 1'b1);
        tick();
        check1 ("mis.inc", pc_inc, 1'b1);
        check32("mis.ipc", bus.instr_pc, 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'd10, 1'b0, 32'h0, 1'b1);
        tick();
        check1("mis.hs", bus.instr_valid, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly downstream of the program counter (pc).
- Samples pc_val, issues a single-outstanding request/acknowledge read to instruction memory, and latches the returned word into an instruction register.
- Presents the latched word to the decoder with a valid/ready handshake.
- Drives the pc increment and hold controls, so the PC advances exactly once per instruction delivered.

Parameters:
NOP_INSTR, 32'h0000_0013, value of instr at reset and after flush (addi x0,x0,0)
WAIT_TIMEOUT, 255, max cycles a request may wait for mem_ack before fetch_err; range 1..65535
TMR_W, 16, width of the wait counter; must satisfy 2**TMR_W > WAIT_TIMEOUT

Ports:
clk  input  1  system clock; all state updates on rising edge
clr  input  1  synchronous active-high reset
fetch_en  input  1  permits launching a new fetch
flush  input  1  branch/jump taken: discard in-flight fetch and held instruction
pc_val  input  32  current PC from pc
pc_inc  output  1  one-cycle pulse to pc.inc: instruction captured
pc_disable  output  1  to pc.Disable: high while a fetch is outstanding or an instruction is held
mem_req  output  1  memory read request
mem_addr  output  32  word address of the request
mem_ack  input  1  memory read data valid
mem_rdata  input  32  memory read data
instr  output  32  held instruction word
instr_pc  output  32  address instr was fetched from
instr_valid  output  1  instr is valid for the decoder
instr_ready  input  1  decoder accepts instr
fetch_err  output  1  sticky timeout flag
misalign  output  1  sticky misaligned-PC flag (see Optional Feature)

Behaviour:
- Reset (clr=1 at an edge) forces: state IDLE, mem_req=0, mem_addr=0, instr=NOP_INSTR, instr_pc=0, instr_valid=0, pc_inc=0, fetch_err=0, misalign=0, timer=0. A clr in the middle of a fetch abandons the fetch.
- All outputs are registered. pc_disable is high in every state except IDLE.
- IDLE:
  - If fetch_en=1 and flush=0: mem_req<=1, mem_addr<={pc_val[31:2],2'b00}, timer<=0, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - mem_req and mem_addr are held stable until mem_ack.
  - When mem_ack=1: mem_req<=0, instr<=mem_rdata, instr_pc<=mem_addr, instr_valid<=1, pc_inc<=1 for exactly one cycle, go to HOLD.
  - When mem_ack=0: timer increments. When timer reaches WAIT_TIMEOUT-1 without an ack: mem_req<=0, fetch_err<=1, go to IDLE. No pc_inc is issued.
- HOLD:
  - instr_valid stays high and instr stays stable until instr_ready=1.
  - On the handshake: instr_valid<=0, go to IDLE.
  - The next launch therefore occurs no earlier than 2 cycles after pc_inc, so pc_val is guaranteed already updated. Minimum cadence: 1 instruction per 3 cycles plus memory latency.
- flush:
  - Takes priority over everything except clr, in every state.
  - Effects: mem_req<=0, instr_valid<=0, instr<=NOP_INSTR, pc_inc<=0, fetch_err<=0, misalign<=0, go to IDLE.
  - A mem_ack in the same cycle as flush is discarded and produces no pc_inc.
- Memory protocol:
  - Only one request is outstanding at a time.
  - mem_ack is honoured only while mem_req=1. mem_ack while mem_req=0 is ignored.
  - Deasserting mem_req cancels the request.
- fetch_err blocks further launches; IDLE stays idle until flush or clr.
- fetch_en=0 in WAIT or HOLD does not cancel the current fetch. It only suppresses the next launch.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: in IDLE, a launch condition with pc_val[1:0]!=2'b00 issues no request. Instead misalign<=1 (sticky, cleared by flush/clr) and the unit stays in IDLE, with pc_disable low and pc_inc never pulsed. Launches are blocked while misalign=1.
- Undefined: pc_val[1:0] is silently forced to 00 in mem_addr, and misalign is tied to 0.

Test Plan:
1. Reset, pc_val=0, fetch_en=1, memory acks 2 cycles after req with 32'h00500093, instr_ready=1 -> mem_addr=0, instr=32'h00500093, instr_pc=0, one pc_inc pulse, instr_valid drops after the handshake.
2. Back-to-back fetches, pc_val 0->4 driven by pc_inc -> second mem_addr=4, exactly two pc_inc pulses total, no request issued before pc_val=4.
3. instr_ready=0 for 5 cycles after capture -> instr_valid and instr held stable for 5 cycles, mem_req=0, pc_disable=1, no second pc_inc.
4. flush asserted in the same cycle as mem_ack, pc_val=8 -> no pc_inc, instr=NOP_INSTR, instr_valid=0. The next fetch addresses pc_val (e.g. 32) once flush is released.
5. WAIT_TIMEOUT=4, no mem_ack -> mem_req drops after 4 cycles, fetch_err=1, no further requests until flush.
6. With FETCH_MISALIGN_TRAP_EN defined and pc_val=6 -> misalign=1, mem_req stays 0. Without the macro -> mem_addr=4 and misalign=0.
